// File: rtl/sram_port_arbiter.sv
// Arbiter sharing one synchronous single-port SRAM between fetch (read-only) and MEM (read/write).
// Optional performance counters are enabled by defining ARB_PERF_CNT_EN.
module sram_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic [95:0] perf_cnt
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_e           state_q;
  logic             owner_q;
  logic             wr_q;
  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;
  logic             force_inst_s;
  logic             gnt_inst_s;
  logic             gnt_data_s;
  logic             gnt_any_s;

  // Grant selection; resetn gates it so nothing is accepted while reset is held.
  always_comb begin
    force_inst_s = inst_req & (starve_q == LIMIT);
    gnt_inst_s   = 1'b0;
    gnt_data_s   = 1'b0;
    if (!resetn) begin
      gnt_inst_s = 1'b0;
    end else if (force_inst_s) begin
      gnt_inst_s = 1'b1;
    end else if (data_req) begin
      gnt_data_s = 1'b1;
    end else if (inst_req) begin
      gnt_inst_s = 1'b1;
    end else begin
      gnt_data_s = 1'b0;
    end
  end

  assign gnt_any_s    = gnt_inst_s | gnt_data_s;
  assign inst_addr_ok = gnt_inst_s;
  assign data_addr_ok = gnt_data_s;

  // SRAM request port driven from the winner.
  always_comb begin
    sram_en    = gnt_any_s;
    sram_we    = (gnt_data_s & data_wr) ? data_wstrb : 4'b0000;
    sram_wdata = gnt_data_s ? data_wdata : 32'h0000_0000;
    if (gnt_data_s) begin
      sram_addr = data_addr;
    end else if (gnt_inst_s) begin
      sram_addr = inst_addr;
    end else begin
      sram_addr = 32'h0000_0000;
    end
  end

  // Starvation counter next state: saturates at the limit, clears once inst wins or withdraws.
  always_comb begin
    if (inst_req & ~gnt_inst_s) begin
      starve_d = (starve_q == LIMIT) ? starve_q : starve_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      starve_d = {CNT_W{1'b0}};
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_q <= {CNT_W{1'b0}};
    end else begin
      starve_q <= starve_d;
    end
  end

  // Response FSM: any grant puts one access in flight for the following cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, RESP: begin
          state_q <= gnt_any_s ? RESP : IDLE;
          owner_q <= gnt_data_s;
          wr_q    <= gnt_data_s & data_wr;
        end
        default: begin
          state_q <= IDLE;
          owner_q <= 1'b0;
          wr_q    <= 1'b0;
        end
      endcase
    end
  end

  assign inst_data_ok = (state_q == RESP) & ~owner_q;
  assign data_data_ok = (state_q == RESP) &  owner_q;
  assign inst_rdata   = inst_data_ok ? sram_rdata : 32'h0000_0000;
  assign data_rdata   = (data_data_ok & ~wr_q) ? sram_rdata : 32'h0000_0000;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] inst_cnt_q;
  logic [31:0] data_cnt_q;
  logic [31:0] conf_cnt_q;

  // Performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_cnt_q <= 32'd0;
      data_cnt_q <= 32'd0;
      conf_cnt_q <= 32'd0;
    end else begin
      inst_cnt_q <= inst_cnt_q + {31'd0, gnt_inst_s};
      data_cnt_q <= data_cnt_q + {31'd0, gnt_data_s};
      conf_cnt_q <= conf_cnt_q + {31'd0, inst_req & data_req};
    end
  end

  assign perf_cnt = {inst_cnt_q, data_cnt_q, conf_cnt_q};
`else
  assign perf_cnt = 96'd0;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic [95:0] perf_cnt;

  int checks = 0;
  int errors = 0;

  sram_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .perf_cnt(perf_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 1'b0; inst_addr = 32'h0; data_req = 1'b0; data_wr = 1'b0;
    data_wstrb = 4'h0; data_addr = 32'h0; data_wdata = 32'h0; sram_rdata = 32'h0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    resetn = 1'b0;
    cyc(); cyc();
    resetn = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF;
    sram_rdata = 32'hDEAD_BEEF;
    cyc(); #1;
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin errors++; $display("FAIL rst_addr_ok got %b exp 00", {inst_addr_ok, data_addr_ok}); end
    checks++; if ({sram_en, sram_we} !== 5'b0) begin errors++; $display("FAIL rst_sram got %b exp 00000", {sram_en, sram_we}); end
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("FAIL rst_data_ok got %b exp 00", {inst_data_ok, data_data_ok}); end
    checks++; if ({inst_rdata, data_rdata} !== 64'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", {inst_rdata, data_rdata}); end
    checks++; if (perf_cnt !== 96'h0) begin errors++; $display("FAIL rst_perf got %h exp 0", perf_cnt); end
    idle_inputs();
    resetn = 1'b1;
    cyc();
  endtask

  task automatic test_inst_read();
    inst_req = 1'b1; inst_addr = 32'h1C00_0000;
    #1;
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin errors++; $display("FAIL ird_addr_ok got %b exp 10", {inst_addr_ok, data_addr_ok}); end
    checks++; if ({sram_en, sram_we, sram_addr} !== {1'b1, 4'h0, 32'h1C00_0000}) begin errors++; $display("FAIL ird_sram got %b %b %h exp 1 0000 1c000000", sram_en, sram_we, sram_addr); end
    cyc();
    idle_inputs(); sram_rdata = 32'h0280_0413;
    #1;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin errors++; $display("FAIL ird_data_ok got %b exp 10", {inst_data_ok, data_data_ok}); end
    checks++; if (inst_rdata !== 32'h0280_0413) begin errors++; $display("FAIL ird_rdata got %h exp 02800413", inst_rdata); end
    checks++; if (sram_en !== 1'b0) begin errors++; $display("FAIL ird_idle_en got %b exp 0", sram_en); end
    cyc(); #1;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("FAIL ird_one_pulse got %b exp 00", {inst_data_ok, data_data_ok}); end
  endtask

  task automatic test_store();
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
    data_addr = 32'h0000_0100; data_wdata = 32'hAABB_CCDD;
    #1;
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin errors++; $display("FAIL st_addr_ok got %b exp 01", {inst_addr_ok, data_addr_ok}); end
    checks++; if ({sram_en, sram_we} !== 5'b1_0011) begin errors++; $display("FAIL st_we got %b exp 10011", {sram_en, sram_we}); end
    checks++; if ({sram_addr, sram_wdata} !== {32'h0000_0100, 32'hAABB_CCDD}) begin errors++; $display("FAIL st_addr_wdata got %h %h exp 00000100 aabbccdd", sram_addr, sram_wdata); end
    cyc();
    idle_inputs();
    #1;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin errors++; $display("FAIL st_data_ok got %b exp 01", {inst_data_ok, data_data_ok}); end
    checks++; if (sram_we !== 4'b0000) begin errors++; $display("FAIL st_we_idle got %b exp 0000", sram_we); end
    cyc();
  endtask

  task automatic test_starvation();
    logic exp_inst;
    logic prev_inst;
    apply_reset();
    prev_inst = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h1C00_0040;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0200;
    for (int i = 0; i < 10; i++) begin
      exp_inst = (i == 4) || (i == 9);
      #1;
      checks++; if ({inst_addr_ok, data_addr_ok} !== {exp_inst, ~exp_inst}) begin errors++; $display("FAIL starve_grant cyc %0d got %b exp %b", i, {inst_addr_ok, data_addr_ok}, {exp_inst, ~exp_inst}); end
      if (i > 0) begin
        checks++; if ({inst_data_ok, data_data_ok} !== {prev_inst, ~prev_inst}) begin errors++; $display("FAIL starve_owner cyc %0d got %b exp %b", i, {inst_data_ok, data_data_ok}, {prev_inst, ~prev_inst}); end
      end
      prev_inst = exp_inst;
      cyc();
    end
    idle_inputs();
    #1;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin errors++; $display("FAIL starve_last_owner got %b exp 10", {inst_data_ok, data_data_ok}); end
`ifdef ARB_PERF_CNT_EN
    checks++; if (perf_cnt !== {32'd2, 32'd8, 32'd10}) begin errors++; $display("FAIL perf_cnt got %h exp {2,8,10}", perf_cnt); end
`else
    checks++; if (perf_cnt !== 96'd0) begin errors++; $display("FAIL perf_cnt_off got %h exp 0", perf_cnt); end
`endif
    cyc();
  endtask

  task automatic test_back_to_back();
    inst_req = 1'b1; inst_addr = 32'h1C00_0010;
    #1;
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin errors++; $display("FAIL b2b_g0 got %b exp 10", {inst_addr_ok, data_addr_ok}); end
    cyc();
    inst_req = 1'b0; data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0300;
    sram_rdata = 32'h1111_1111;
    #1;
    checks++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0110) begin errors++; $display("FAIL b2b_c1 got %b exp 0110", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
    checks++; if (inst_rdata !== 32'h1111_1111) begin errors++; $display("FAIL b2b_irdata got %h exp 11111111", inst_rdata); end
    cyc();
    data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h1C00_0014;
    sram_rdata = 32'h2222_2222;
    #1;
    checks++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b1001) begin errors++; $display("FAIL b2b_c2 got %b exp 1001", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
    checks++; if ({data_rdata, inst_rdata} !== {32'h2222_2222, 32'h0}) begin errors++; $display("FAIL b2b_drdata got %h %h exp 22222222 0", data_rdata, inst_rdata); end
    cyc();
    idle_inputs(); sram_rdata = 32'h3333_3333;
    #1;
    checks++; if ({inst_data_ok, data_data_ok, inst_rdata} !== {2'b10, 32'h3333_3333}) begin errors++; $display("FAIL b2b_c3 got %b %h exp 10 33333333", {inst_data_ok, data_data_ok}, inst_rdata); end
    cyc();
  endtask

  task automatic test_reset_mid_access();
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0400;
    #1;
    checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL rmid_grant got %b exp 1", data_addr_ok); end
    @(posedge clk);
    resetn = 1'b0;
    sram_rdata = 32'h5555_AAAA;
    #2;
    checks++; if ({data_data_ok, inst_data_ok, data_rdata} !== 34'h0) begin errors++; $display("FAIL rmid_no_resp got %b %h exp 0 0", data_data_ok, data_rdata); end
    checks++; if ({data_addr_ok, sram_en, sram_we} !== 6'b0) begin errors++; $display("FAIL rmid_outputs got %b exp 000000", {data_addr_ok, sram_en, sram_we}); end
    cyc(); #1;
    checks++; if ({data_data_ok, data_addr_ok, sram_en} !== 3'b000) begin errors++; $display("FAIL rmid_held got %b exp 000", {data_data_ok, data_addr_ok, sram_en}); end
    idle_inputs();
    resetn = 1'b1;
    cyc(); #1;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("FAIL rmid_after got %b exp 00", {inst_data_ok, data_data_ok}); end
  endtask

  initial begin
    idle_inputs();
    resetn = 1'b0;
    test_reset();
    test_inst_read();
    test_store();
    test_starvation();
    test_back_to_back();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
